// File: rtl/tc_alu_bist_ctrl.sv
// tc_alu_bist_ctrl: LFSR-driven self-test of the TC add/multiply ALU, MISR signature.
// Define TC_BIST_SCAN_EN to build the seed/signature scan chain.
module tc_alu_bist_ctrl #(
  parameter int             W      = 8,
  parameter int             N_PAT  = 32,
  parameter logic [W-1:0]   POLY   = 8'h38,
  parameter logic [2*W-1:0] MPOLY  = 16'h6800,
  parameter logic [2*W-1:0] GOLDEN = 16'h0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic           sel,
  input  logic           START,
  input  logic [W-1:0]   SEED_A,
  input  logic [W-1:0]   SEED_B,
  input  logic           SI_EN,
  input  logic           SI,
  output logic           SO,
  output logic [2*W-1:0] Y,
  output logic [2*W-1:0] MISR_OUT,
  output logic           BUSY,
  output logic           DONE,
  output logic           PASS
);
  localparam int CW = $clog2(N_PAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   lfsr_a, lfsr_b;
  logic [W-1:0]   seed_a, seed_b;
  logic [2*W-1:0] y, misr, misr_nx, fold;
  logic [CW-1:0]  cnt, cnt_inc;
  logic           done_q, pass_q;
  logic           run, go, last, scan;

  function automatic logic [2*W-1:0] alu(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         s
  );
    logic [2*W-1:0] ax, bx;
    ax = {{W{1'b0}}, a};
    bx = {{W{1'b0}}, b};
    return s ? ax * bx : ax + bx;
  endfunction

  function automatic logic [W-1:0] lfsr_step(
    input logic [W-1:0] q
  );
    logic [W-1:0] n;
    n[W-1] = q[0];
    for (int i = 0; i < W-1; i++)
      n[i] = q[i+1] ^ (POLY[i] & q[0]);
    return n;
  endfunction

`ifdef TC_BIST_SCAN_EN
  logic shift;
  assign scan  = SI_EN;
  assign shift = !run && scan;
  assign SO    = misr[2*W-1];
`else
  logic unused_scan;
  assign unused_scan = SI ^ SI_EN;
  assign scan        = 1'b0;
  assign SO          = 1'b0;
`endif

  assign run     = (state == S_RUN);
  assign go      = !run && !scan && START;
  assign cnt_inc = cnt + 1'b1;
  assign last    = run && (cnt_inc == CW'(N_PAT));

  // all-zero seeds would lock the LFSRs up
  assign seed_a = (SEED_A == '0) ? W'(1) : SEED_A;
  assign seed_b = (SEED_B == '0) ? W'(1) : SEED_B;

  always_comb begin
    fold    = '0;
    misr_nx = '0;
    for (int i = 0; i < W; i++)
      fold[i] = y[2*i+1] ^ y[2*i];
    misr_nx[0] = misr[2*W-1] ^ fold[0];
    for (int i = 1; i < 2*W; i++)
      misr_nx[i] = misr[i-1] ^ fold[i]
                 ^ (MPOLY[i] & misr[2*W-1]);
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      go:      state_nx = S_RUN;
      last:    state_nx = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a <= '0;
      lfsr_b <= '0;
      y      <= '0;
      misr   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      unique case (1'b1)
        run: begin
          lfsr_a <= lfsr_step(lfsr_a);
          lfsr_b <= lfsr_step(lfsr_b);
          y      <= alu(lfsr_a, lfsr_b, lfsr_a[0]);
          misr   <= misr_nx;
          cnt    <= cnt_inc;
          if (last) begin
            done_q <= 1'b1;
            pass_q <= (misr_nx == GOLDEN);
          end
        end
        go: begin
          lfsr_a <= seed_a;
          lfsr_b <= seed_b;
          y      <= alu(seed_a, seed_b, seed_a[0]);
          misr   <= '0;
          cnt    <= '0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end
`ifdef TC_BIST_SCAN_EN
        shift: begin
          lfsr_a <= {SI, lfsr_a[W-1:1]};
          lfsr_b <= {lfsr_a[0], lfsr_b[W-1:1]};
          misr   <= {misr[2*W-2:0], lfsr_b[0]};
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end
`endif
        default: y <= alu(A, B, sel);
      endcase
    end
  end

  assign Y        = y;
  assign MISR_OUT = misr;
  assign BUSY     = run;
  assign DONE     = done_q;
  assign PASS     = pass_q;

endmodule

// File: tb/tb_tc_alu_bist_ctrl.sv
// tb_tc_alu_bist_ctrl: table + scoreboard bench for tc_alu_bist_ctrl.
// Two instances share stimulus; the second has GOLDEN bit 0 flipped.
module tb_tc_alu_bist_ctrl;
  localparam int          W     = 8;
  localparam int          N     = 32;
  localparam logic [7:0]  POLY  = 8'h38;
  localparam logic [15:0] MPOLY = 16'h6800;

  function automatic logic [15:0] f_ref(
    input logic [7:0] a, input logic [7:0] b, input logic s
  );
    int unsigned r;
    r = s ? int'(a) * int'(b) : int'(a) + int'(b);
    return r[15:0];
  endfunction

  function automatic logic [7:0] lstep(input logic [7:0] c);
    logic [7:0] r;
    r = {c[0], c[7:1]};
    if (c[0]) r = r ^ {1'b0, POLY[6:0]};
    return r;
  endfunction

  function automatic logic [15:0] mstep(
    input logic [15:0] m, input logic [15:0] yv
  );
    logic [7:0]  fd;
    logic [15:0] r;
    for (int i = 0; i < 8; i++) fd[i] = yv[2*i+1] ^ yv[2*i];
    r = {m[14:0], m[15]} ^ {8'h00, fd};
    if (m[15]) r = r ^ (MPOLY & 16'hFFFE);
    return r;
  endfunction

  function automatic logic [15:0] sig_of(
    input logic [7:0] sa, input logic [7:0] sb
  );
    logic [7:0]  la, lb;
    logic [15:0] yv, ny, mm;
    la = (sa == 8'h00) ? 8'h01 : sa;
    lb = (sb == 8'h00) ? 8'h01 : sb;
    yv = f_ref(la, lb, la[0]);
    mm = 16'h0000;
    for (int k = 0; k < N; k++) begin
      ny = f_ref(la, lb, la[0]);
      mm = mstep(mm, yv);
      la = lstep(la);
      lb = lstep(lb);
      yv = ny;
    end
    return mm;
  endfunction

  localparam logic [15:0] G  = sig_of(8'hB3, 8'h3B);
  localparam logic [15:0] GB = G ^ 16'h0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a, b, seed_a, seed_b;
  logic        sel, start, si_en, si;
  logic        so, busy, done, pass;
  logic [15:0] y, misr_out;
  logic        so2, busy2, done2, pass2;
  logic [15:0] y2, misr2;

  tc_alu_bist_ctrl #(
    .W(W), .N_PAT(N), .POLY(POLY), .MPOLY(MPOLY), .GOLDEN(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .sel(sel),
    .START(start), .SEED_A(seed_a), .SEED_B(seed_b),
    .SI_EN(si_en), .SI(si), .SO(so), .Y(y), .MISR_OUT(misr_out),
    .BUSY(busy), .DONE(done), .PASS(pass)
  );

  tc_alu_bist_ctrl #(
    .W(W), .N_PAT(N), .POLY(POLY), .MPOLY(MPOLY), .GOLDEN(GB)
  ) dut_bad (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .sel(sel),
    .START(start), .SEED_A(seed_a), .SEED_B(seed_b),
    .SI_EN(si_en), .SI(si), .SO(so2), .Y(y2), .MISR_OUT(misr2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] y;
    logic [15:0] misr;
    logic        busy, done, pass, pbad;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0]  m_a = 8'h00, m_b = 8'h00;
  logic [15:0] m_y = 16'h0000, m_misr = 16'h0000;
  logic        m_run = 1'b0, m_done = 1'b0;
  logic        m_pass = 1'b0, m_pbad = 1'b0;
  int          m_cnt = 0;

  task automatic push_exp();
    exp_t e;
    e.y = m_y; e.misr = m_misr; e.busy = m_run;
    e.done = m_done; e.pass = m_pass; e.pbad = m_pbad;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    logic so_e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
`ifdef TC_BIST_SCAN_EN
    so_e = e.misr[15];
`else
    so_e = 1'b0;
`endif
    chk({tag, "_y"}, y, e.y);
    chk({tag, "_misr"}, misr_out, e.misr);
    chk({tag, "_busy"}, busy, e.busy);
    chk({tag, "_done"}, done, e.done);
    chk({tag, "_pass"}, pass, e.pass);
    chk({tag, "_done_b"}, done2, e.done);
    chk({tag, "_pass_b"}, pass2, e.pbad);
    chk({tag, "_so"}, so, so_e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_start(input logic [7:0] sa, input logic [7:0] sb);
    m_a = (sa == 8'h00) ? 8'h01 : sa;
    m_b = (sb == 8'h00) ? 8'h01 : sb;
    m_y = f_ref(m_a, m_b, m_a[0]);
    m_misr = 16'h0000; m_cnt = 0; m_run = 1'b1;
    m_done = 1'b0; m_pass = 1'b0; m_pbad = 1'b0;
  endtask

  task automatic m_step();
    logic [15:0] ny;
    ny = f_ref(m_a, m_b, m_a[0]);
    m_misr = mstep(m_misr, m_y);
    m_a = lstep(m_a);
    m_b = lstep(m_b);
    m_y = ny;
    m_cnt++;
    if (m_cnt == N) begin
      m_run = 1'b0; m_done = 1'b1;
      m_pass = (m_misr == G);
      m_pbad = (m_misr == GB);
    end
  endtask

  task automatic do_run(input logic [7:0] sa, input logic [7:0] sb,
                        input bit noise, input int abort_at);
    int nb;
    nb = 0;
    start = 1'b1; seed_a = sa; seed_b = sb;
    m_start(sa, sb);
    push_exp();
    tick();
    pop_chk("e0");
    if (busy) nb++;
    start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        a      = 8'($urandom);
        b      = 8'($urandom);
        sel    = 1'($urandom_range(0, 1));
        seed_a = 8'($urandom);
      end
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_y", y, 16'h0000);
        chk("rst_misr", misr_out, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_so", so, 1'b0);
        m_a = 8'h00; m_b = 8'h00; m_y = 16'h0000;
        m_misr = 16'h0000; m_run = 1'b0; m_done = 1'b0;
        m_pass = 1'b0; m_pbad = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_y = f_ref(a, b, sel);
        push_exp();
        tick();
        pop_chk("post_rst");
        return;
      end
      m_step();
      push_exp();
      tick();
      pop_chk("run");
      if (busy) nb++;
    end
    start = 1'b0;
    chk("busy_cycles", 32'(nb), 32'(N));
  endtask

  typedef struct {
    logic [7:0]  a, b;
    logic        s;
    logic [15:0] y;
  } vec_t;

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pat;
    logic [15:0] em, y_hold, mis_hold;

    vt[0] = '{8'h12, 8'h34, 1'b0, 16'h0046};
    vt[1] = '{8'h12, 8'h34, 1'b1, 16'h03A8};
    vt[2] = '{8'hFF, 8'hFF, 1'b0, 16'h01FE};
    vt[3] = '{8'hFF, 8'hFF, 1'b1, 16'hFE01};
    vt[4] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    vt[5] = '{8'h80, 8'h02, 1'b1, 16'h0100};

    rst_n = 1'b0; a = 8'h00; b = 8'h00; sel = 1'b0;
    start = 1'b0; seed_a = 8'h00; seed_b = 8'h00;
    si_en = 1'b0; si = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_y", y, 16'h0000);
    chk("reset_misr", misr_out, 16'h0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_pass", pass, 1'b0);
    chk("reset_so", so, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      a = vt[i].a; b = vt[i].b; sel = vt[i].s;
      m_y = vt[i].y;
      push_exp();
      tick();
      pop_chk("func");
    end

    do_run(8'hB3, 8'h3B, 1'b0, 0);
    chk("golden_pass", pass, 1'b1);
    chk("golden_bad_pass", pass2, 1'b0);

`ifdef TC_BIST_SCAN_EN
    pat = 32'hA5C3_0F96;
    y_hold = y;
    si_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      si = pat[k];
      tick();
    end
    for (int j = 0; j < 16; j++) em[j] = pat[15-j];
    chk("scan_misr", misr_out, em);
    chk("scan_done", done, 1'b0);
    chk("scan_pass", pass, 1'b0);
    chk("scan_y_hold", y, y_hold);
    for (int k = 0; k < 32; k++) begin
      chk("scan_so", so, pat[k]);
      si = 1'b0;
      tick();
    end
    si_en = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_misr = 16'h0000;
    m_done = 1'b0; m_pass = 1'b0; m_pbad = 1'b0;
`else
    pat = 32'h0;
    em = 16'h0;
    y_hold = 16'h0;
    mis_hold = misr_out;
    for (int k = 0; k < 8; k++) begin
      si_en = k[0]; si = k[1];
      a = 8'(k * 17); b = 8'(k + 3); sel = k[2];
      m_y = f_ref(a, b, sel);
      push_exp();
      tick();
      pop_chk("noscan");
    end
    chk("noscan_misr_hold", misr_out, mis_hold);
    si_en = 1'b0; si = 1'b0;
`endif

    do_run(8'h00, 8'h00, 1'b0, 0);
    do_run(8'hB3, 8'h3B, 1'b1, 0);
    chk("noise_pass", pass, 1'b1);
    chk("noise_sig", misr_out, G);
    do_run(8'hB3, 8'h3B, 1'b0, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
